// File: rtl/dmem_access_ctrl_pkg.sv
// dmem_access_ctrl_pkg: access-size and sequencer-state types plus the alignment legality check
package dmem_access_ctrl_pkg;
  typedef enum logic [1:0] {
    byte_size     = 2'b00,
    halfword_size = 2'b01,
    word_size     = 2'b11
  } mem_size_t;
  typedef enum logic [1:0] {DM_IDLE, DM_REQ, DM_WAIT, DM_DONE} dmem_state_t;
  function automatic logic access_fault(input logic [1:0] size, input logic [1:0] off);
    return (size == 2'b10) || (size == halfword_size && off[0]) || (size == word_size && off != 2'b00);
  endfunction
endpackage

// File: rtl/dmem_lane_align.sv
// dmem_lane_align: size/off/zero_ext/wdata/rdata in -> byte enables, lane-replicated store data, extended load data out
module dmem_lane_align
  import dmem_access_ctrl_pkg::*;
(
  input  logic [1:0]  size,
  input  logic [1:0]  off,
  input  logic        zero_ext,
  input  logic [31:0] wdata,
  input  logic [31:0] rdata,
  output logic [3:0]  be,
  output logic [31:0] wdata_rep,
  output logic [31:0] rdata_ext
);
  logic [7:0]  rb;
  logic [15:0] rh;
  always_comb begin
    rb = rdata[{off, 3'b000} +: 8];
    rh = rdata[{off[1], 4'b0000} +: 16];
    be = size == byte_size ? 4'b0001 << off : size == halfword_size ? 4'b0011 << {off[1], 1'b0} : 4'b1111;
    wdata_rep = size == byte_size ? {4{wdata[7:0]}} : size == halfword_size ? {2{wdata[15:0]}} : wdata;
    rdata_ext = size == byte_size ? {{24{rb[7] & ~zero_ext}}, rb}
              : size == halfword_size ? {{16{rh[15] & ~zero_ext}}, rh} : rdata;
  end
endmodule

// File: rtl/dmem_access_ctrl.sv
// dmem_access_ctrl: core load/store fields (core_*) -> valid/ready data-memory port (mem_*), with stall/done/err handshake back to the core
module dmem_access_ctrl
  import dmem_access_ctrl_pkg::*;
#(
  parameter int TIMEOUT = 255
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        core_valid,
  input  logic        core_write,
  input  logic [1:0]  core_size,
  input  logic        core_zero_ext,
  input  logic [31:0] core_addr,
  input  logic [31:0] core_wdata,
  output logic        core_stall,
  output logic        core_done,
  output logic        core_err,
  output logic [31:0] core_rdata,
  output logic        mem_req_valid,
  input  logic        mem_req_ready,
  output logic        mem_we,
  output logic [3:0]  mem_be,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  input  logic        mem_rsp_valid,
  input  logic [31:0] mem_rdata
);
  localparam int CW = TIMEOUT > 0 ? $clog2(TIMEOUT + 1) : 1;
  localparam logic [CW-1:0] TLIM = CW'(TIMEOUT - 1);
  dmem_state_t state, nxt;
  logic [CW-1:0] cnt;
  logic [1:0] size_q, off_q;
  logic zext_q, err_q, illegal, tmo;
  logic [31:0] rdata_q, wdata_rep, rdata_ext;
  logic [3:0] be;
  // In IDLE the aligner works on the live request; afterwards on the latched copy for load extraction.
  dmem_lane_align u_align (
    .size      (state == DM_IDLE ? core_size : size_q),
    .off       (state == DM_IDLE ? core_addr[1:0] : off_q),
    .zero_ext  (zext_q),
    .wdata     (core_wdata),
    .rdata     (mem_rdata),
    .be        (be),
    .wdata_rep (wdata_rep),
    .rdata_ext (rdata_ext)
  );
  assign mem_req_valid = state == DM_REQ;
  assign core_done = state == DM_DONE;
  assign core_err = core_done & err_q;
  assign core_rdata = core_done ? rdata_q : '0;
  assign core_stall = core_valid & ~core_done;
  always_comb begin
    illegal = access_fault(core_size, core_addr[1:0]);
    tmo = (TIMEOUT != 0) && (cnt == TLIM);
    nxt = state;
    case (state)
      DM_IDLE: nxt = core_valid ? (illegal ? DM_DONE : DM_REQ) : DM_IDLE;
      DM_REQ:  nxt = mem_req_ready ? DM_WAIT : tmo ? DM_DONE : DM_REQ;
      DM_WAIT: nxt = (mem_rsp_valid || tmo) ? DM_DONE : DM_WAIT;
      default: nxt = DM_IDLE;
    endcase
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= DM_IDLE;
      cnt <= '0;
      size_q <= '0;
      off_q <= '0;
      zext_q <= 1'b0;
      err_q <= 1'b0;
      rdata_q <= '0;
      mem_we <= 1'b0;
      mem_be <= '0;
      mem_addr <= '0;
      mem_wdata <= '0;
    end else begin
      state <= nxt;
      cnt <= state == DM_IDLE ? '0 : cnt + 1'b1;
      if (state == DM_IDLE && core_valid) begin
        err_q <= illegal;
        rdata_q <= '0;
        if (!illegal) begin
          size_q <= core_size;
          off_q <= core_addr[1:0];
          zext_q <= core_zero_ext;
          mem_we <= core_write;
          mem_be <= be;
          mem_addr <= {core_addr[31:2], 2'b00};
          mem_wdata <= wdata_rep;
        end
      end
      // A response wins over a same-cycle timeout; any other exit to DONE from REQ/WAIT is a timeout.
      if (state == DM_WAIT && mem_rsp_valid)
        rdata_q <= mem_we ? '0 : rdata_ext;
      else if (state != DM_IDLE && nxt == DM_DONE)
        err_q <= 1'b1;
    end
  end
endmodule

// File: tb/tb_dmem_access_ctrl.sv
// tb_dmem_access_ctrl: table-driven, hand-sequenced and randomized checks of dmem_access_ctrl against a byte-level reference model
module tb_dmem_access_ctrl;
  import dmem_access_ctrl_pkg::*;
  logic clk = 1'b0, rst, core_valid, core_write, core_zero_ext, core_stall, core_done, core_err;
  logic [1:0] core_size;
  logic [31:0] core_addr, core_wdata, core_rdata, mem_addr, mem_wdata, mem_rdata;
  logic mem_req_valid, mem_req_ready, mem_we, mem_rsp_valid;
  logic [3:0] mem_be;
  int checks = 0, errors = 0;
  logic r_done, r_err, r_req, r_we, r_stable, r_stall, r_pulse;
  logic [31:0] r_rd, r_addr, r_wd;
  logic [3:0] r_be;
  int r_lat;
  typedef struct {
    logic we; logic [1:0] size; logic zx; logic [31:0] addr, wd, mrd;
    int dr, ds; logic [3:0] be; logic [31:0] ewd, erd; logic err; int lat;
  } vec_t;
  vec_t tab[12];
  always #5 clk = ~clk;
  dmem_access_ctrl #(.TIMEOUT(8)) dut (
    .clk(clk), .rst(rst), .core_valid(core_valid), .core_write(core_write), .core_size(core_size),
    .core_zero_ext(core_zero_ext), .core_addr(core_addr), .core_wdata(core_wdata), .core_stall(core_stall),
    .core_done(core_done), .core_err(core_err), .core_rdata(core_rdata), .mem_req_valid(mem_req_valid),
    .mem_req_ready(mem_req_ready), .mem_we(mem_we), .mem_be(mem_be), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_rsp_valid(mem_rsp_valid), .mem_rdata(mem_rdata)
  );
  task automatic chk(input string n, input logic [31:0] a, input logic [31:0] e);
    checks++;
    if (a !== e) begin
      errors++;
      $display("FAIL %s got=%h want=%h", n, a, e);
    end
  endtask
  // Drives one access; the memory raises ready after dr refused request cycles and
  // answers on the ds-th cycle after acceptance. Observations land in r_*.
  task automatic access(input logic we, input logic [1:0] sz, input logic zx, input logic [31:0] ad, wd, mrd,
                        input int dr, input int ds);
    int rc = 0, wc = 0;
    bit acc = 0;
    core_write = we; core_size = sz; core_zero_ext = zx; core_addr = ad; core_wdata = wd;
    mem_rdata = mrd; core_valid = 1'b1; mem_req_ready = 1'b0; mem_rsp_valid = 1'b0;
    r_done = 0; r_req = 0; r_stable = 1; r_stall = 1; r_lat = 0; r_err = 0; r_rd = '0;
    for (int c = 1; c <= 40 && !r_done; c++) begin
      @(negedge clk);
      if (core_done) begin
        r_done = 1; r_lat = c; r_err = core_err; r_rd = core_rdata;
        if (core_stall) r_stall = 0;
      end else begin
        if (!core_stall) r_stall = 0;
        if (mem_req_valid) begin
          if (!r_req) begin
            r_req = 1; r_be = mem_be; r_addr = mem_addr; r_we = mem_we; r_wd = mem_wdata;
          end else if ({mem_be, mem_addr, mem_we, mem_wdata} != {r_be, r_addr, r_we, r_wd}) r_stable = 0;
          rc++;
        end
        if (acc) wc++;
        mem_req_ready = mem_req_valid && rc > dr;
        mem_rsp_valid = acc && wc >= ds;
        if (mem_req_ready) acc = 1;
      end
    end
    core_valid = 1'b0; mem_req_ready = 1'b0; mem_rsp_valid = 1'b0;
    @(negedge clk);
    r_pulse = !core_done;
  endtask
  task automatic check_vec(input string n, input vec_t v);
    chk({n, ".done"}, 32'(r_done), 1);
    chk({n, ".lat"}, r_lat, v.lat);
    chk({n, ".err"}, 32'(r_err), 32'(v.err));
    chk({n, ".rdata"}, r_rd, v.erd);
    chk({n, ".stall"}, 32'(r_stall), 1);
    chk({n, ".pulse"}, 32'(r_pulse), 1);
    chk({n, ".req"}, 32'(r_req), 32'(v.lat != 1));
    if (v.lat != 1 && r_req) begin
      chk({n, ".be"}, 32'(r_be), 32'(v.be));
      chk({n, ".addr"}, r_addr, {v.addr[31:2], 2'b00});
      chk({n, ".we"}, 32'(r_we), 32'(v.we));
      chk({n, ".stable"}, 32'(r_stable), 1);
      if (v.we) chk({n, ".wdata"}, r_wd, v.ewd);
    end
  endtask
  // Reference model: derived from access width in bytes and the byte offset.
  function automatic vec_t model(input logic we, input logic [1:0] sz, input logic zx,
                                 input logic [31:0] ad, wd, mrd, input int dr, input int ds);
    vec_t v;
    int nb = sz == 2'b00 ? 1 : sz == 2'b01 ? 2 : 4;
    int off = int'(ad[1:0]);
    int bei = ((1 << nb) - 1) << off;
    logic [31:0] val = mrd >> (8 * off);
    logic [31:0] mask = nb == 4 ? 32'hFFFF_FFFF : (32'd1 << (8 * nb)) - 1;
    v.we = we; v.size = sz; v.zx = zx; v.addr = ad; v.wd = wd; v.mrd = mrd; v.dr = dr; v.ds = ds;
    v.err = sz == 2'b10 || (off % nb) != 0;
    v.be = bei[3:0];
    for (int i = 0; i < 4; i++) v.ewd[8 * i +: 8] = wd[8 * (i % nb) +: 8];
    val = val & mask;
    if (!zx && nb < 4 && val[8 * nb - 1]) val = val | ~mask;
    v.erd = (v.err || we) ? 32'h0 : val;
    v.lat = v.err ? 1 : 1 + (dr + 1) + ds;
    return v;
  endfunction
  initial begin
    tab[0]  = '{0, 2'b00, 0, 32'h103, 0, 32'h80FF_1234, 0, 1, 4'b1000, 0, 32'hFFFF_FF80, 0, 3};
    tab[1]  = '{0, 2'b01, 1, 32'h102, 0, 32'hBEEF_0000, 0, 1, 4'b1100, 0, 32'h0000_BEEF, 0, 3};
    tab[2]  = '{0, 2'b01, 0, 32'h102, 0, 32'hBEEF_0000, 0, 1, 4'b1100, 0, 32'hFFFF_BEEF, 0, 3};
    tab[3]  = '{1, 2'b00, 0, 32'h201, 32'hAB, 0, 4, 1, 4'b0010, 32'hABAB_ABAB, 0, 0, 7};
    tab[4]  = '{0, 2'b11, 0, 32'h302, 0, 32'h1111_1111, 0, 1, 4'b0000, 0, 0, 1, 1};
    tab[5]  = '{0, 2'b10, 0, 32'h300, 0, 32'h1111_1111, 0, 1, 4'b0000, 0, 0, 1, 1};
    tab[6]  = '{1, 2'b11, 0, 32'h0, 32'h1234_5678, 0, 0, 1, 4'b1111, 32'h1234_5678, 0, 0, 3};
    tab[7]  = '{0, 2'b00, 1, 32'h101, 0, 32'h0000_9A00, 1, 2, 4'b0010, 0, 32'h0000_009A, 0, 5};
    tab[8]  = '{0, 2'b11, 0, 32'h8, 0, 32'hDEAD_BEEF, 3, 4, 4'b1111, 0, 32'hDEAD_BEEF, 0, 9};
    tab[9]  = '{0, 2'b11, 0, 32'hC, 0, 32'h5555_5555, 100, 1, 4'b1111, 0, 0, 1, 9};
    tab[10] = '{0, 2'b11, 0, 32'h10, 0, 32'h5555_5555, 0, 100, 4'b1111, 0, 0, 1, 9};
    tab[11] = '{1, 2'b01, 0, 32'h202, 32'h0000_CAFE, 0, 0, 1, 4'b1100, 32'hCAFE_CAFE, 0, 0, 3};
    rst = 1'b1; core_valid = 0; core_write = 0; core_size = 0; core_zero_ext = 0;
    core_addr = 0; core_wdata = 0; mem_req_ready = 0; mem_rsp_valid = 0; mem_rdata = 0;
    repeat (2) @(negedge clk);
    chk("reset_outs", 32'(|{core_stall, core_done, core_err, core_rdata, mem_req_valid, mem_we, mem_be, mem_addr, mem_wdata}), 0);
    rst = 1'b0;
    @(negedge clk);
    for (int i = 0; i < 12; i++) begin
      access(tab[i].we, tab[i].size, tab[i].zx, tab[i].addr, tab[i].wd, tab[i].mrd, tab[i].dr, tab[i].ds);
      check_vec($sformatf("vec%0d", i), tab[i]);
    end
    // late response after a timeout must not produce a completion or request
    begin
      logic seen = 0;
      mem_rsp_valid = 1'b1;
      repeat (3) begin
        @(negedge clk);
        seen = seen | core_done | mem_req_valid | core_stall;
      end
      mem_rsp_valid = 1'b0;
      chk("late_rsp_ignored", 32'(seen), 0);
    end
    // reset while waiting for a response
    begin
      int n = 0;
      core_write = 0; core_size = 2'b11; core_addr = 32'h400; core_valid = 1'b1;
      while (!mem_req_valid && n < 10) begin @(negedge clk); n++; end
      chk("rstw.req_seen", 32'(mem_req_valid), 1);
      mem_req_ready = 1'b1;
      @(negedge clk);
      mem_req_ready = 1'b0;
      chk("rstw.in_wait", 32'(mem_req_valid | core_done), 0);
      rst = 1'b1; core_valid = 1'b0;
      @(negedge clk);
      rst = 1'b0;
      chk("rstw.outs", 32'(|{core_stall, core_done, core_err, core_rdata, mem_req_valid, mem_we, mem_be, mem_addr, mem_wdata}), 0);
      mem_rsp_valid = 1'b1;
      @(negedge clk);
      mem_rsp_valid = 1'b0;
      chk("rstw.rsp_ignored", 32'(core_done | mem_req_valid), 0);
      access(tab[6].we, tab[6].size, tab[6].zx, tab[6].addr, tab[6].wd, tab[6].mrd, tab[6].dr, tab[6].ds);
      check_vec("rstw.sw", tab[6]);
    end
    for (int i = 0; i < 60; i++) begin
      vec_t v;
      logic [1:0] sz;
      int p = $urandom_range(0, 9);
      sz = p < 3 ? 2'b00 : p < 6 ? 2'b01 : p < 9 ? 2'b11 : 2'b10;
      v = model(1'($urandom), sz, 1'($urandom), $urandom, $urandom, $urandom,
                $urandom_range(0, 3), $urandom_range(1, 4));
      access(v.we, v.size, v.zx, v.addr, v.wd, v.mrd, v.dr, v.ds);
      check_vec($sformatf("rnd%0d", i), v);
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/dmem_access_ctrl.md
Name: dmem_access_ctrl

Overview:
Multi-cycle data-memory access sequencer between the RV32I core's load/store control fields (mem_valid, mem_write, mem_size, load_zero_extend) and a valid/ready data-memory port with variable latency. Generates byte enables, aligns store data and extracts/extends load data. Stalls the core until the access completes or faults. Flags misaligned, illegal-size and timed-out accesses.

Parameters:
TIMEOUT, 255, max cycles spent in REQ+WAIT before a bus-timeout fault; 0 disables timeout.

Ports:
clk  in  1  clock
rst  in  1  synchronous, active-high reset
core_valid  in  1  access requested (control_t.mem_valid); held high while core_stall=1
core_write  in  1  1=store, 0=load
core_size  in  2  mem_size_t (byte_size/halfword_size/word_size)
core_zero_ext  in  1  1=zero-extend load (LBU/LHU)
core_addr  in  32  byte address
core_wdata  in  32  store data, LSB-justified
core_stall  out  1  hold PC/writeback
core_done  out  1  one-cycle completion pulse
core_err  out  1  fault, valid with core_done
core_rdata  out  32  extended load data, valid with core_done
mem_req_valid  out  1  request valid
mem_req_ready  in  1  memory accepts request
mem_we  out  1  write enable
mem_be  out  4  byte enables
mem_addr  out  32  word-aligned address ({addr[31:2],2'b00})
mem_wdata  out  32  lane-replicated store data
mem_rsp_valid  in  1  response (read data / write ack)
mem_rdata  in  32  read word

Behaviour:
- All outputs 0 at reset. rst in any state -> IDLE next cycle; mem_req_valid drops; responses arriving afterwards are ignored.
- core_stall = core_valid & ~core_done (combinational).
- FSM IDLE -> REQ -> WAIT -> DONE -> IDLE.
- IDLE: on core_valid, check legality. Fault if: size 2'b10; halfword with addr[0]=1; word with addr[1:0]!=0. On fault: no memory request, go to DONE with err flag. Otherwise latch we, be, aligned addr, wdata, size, zero_ext, addr[1:0]; go to REQ.
- REQ: mem_req_valid=1; all mem_* fields stable until mem_req_ready=1, then go to WAIT.
- WAIT: on mem_rsp_valid, capture mem_rdata and go to DONE. mem_rsp_valid outside WAIT is ignored (including the same cycle as acceptance).
- Timeout counter: cleared on leaving IDLE; increments each cycle in REQ/WAIT. At count == TIMEOUT-1 without progress -> DONE with err, drop mem_req_valid. Counter width $clog2(TIMEOUT+1).
- DONE: core_done=1 and core_err=flag for exactly one cycle; core_rdata = extracted load (0 for stores and faults); -> IDLE.
- Byte enables: byte 4'b0001<<addr[1:0]; half 4'b0011<<{addr[1],1'b0}; word 4'b1111.
- Store data: byte {4{wdata[7:0]}}; half {2{wdata[15:0]}}; word wdata.
- Load extract: byte = rdata[8*addr[1:0]+:8]; half = rdata[16*addr[1]+:16]; sign- or zero-extended per zero_ext; word passes through.
- Latency: with ready=1 on the first REQ cycle and the response one cycle later, core_done asserts 3 cycles after core_valid rises. Back-to-back accesses: a new core_valid is sampled in IDLE on the cycle after DONE.
- Stores also wait for mem_rsp_valid as a write acknowledge.

Decomposition:
- risc_pkg additions: dmem_state_t enum {DM_IDLE, DM_REQ, DM_WAIT, DM_DONE}. Reuse mem_size_t.
- Sub-module dmem_lane_align (combinational): computes be, replicated wdata and extracted/extended rdata from size, addr[1:0] and zero_ext. Instantiated once by the FSM.

Test Plan:
- LB at addr 0x103, mem_rdata 0x80FF_1234, ready=1, rsp next cycle -> mem_be=4'b1000, mem_addr 0x100, core_rdata 0xFFFF_FF80, core_done 3 cycles after valid.
- LHU at 0x102 with rdata 0xBEEF_0000 -> be 4'b1100, rdata 0x0000_BEEF; LH at the same address -> 0xFFFF_BEEF.
- SB at 0x201, wdata 0x0000_00AB, ready held low 4 cycles -> mem_req_valid and fields stable throughout, mem_wdata 0xABAB_ABAB, be 4'b0010, done after ack.
- LW at 0x302 -> no mem_req_valid ever, core_done and core_err for one cycle, core_rdata 0; size 2'b10 -> same result.
- TIMEOUT=8, ready=1, no response -> core_done+core_err exactly 8 cycles after leaving IDLE; a late rsp_valid in IDLE is ignored.
- rst asserted in WAIT -> next cycle IDLE with all outputs 0; a following SW at 0x0 completes normally with be 4'b1111.
